dff_chain_ctrl: RTL and testbench
=================================

# dff_chain_ctrl

Controller that sequences a WIDTH-bit chain of D flip-flops as a parallel-in, serial-out shifter. It accepts a parallel word on a valid/ready handshake, loads the chain, and shifts the word out LSB first on a second valid/ready handshake. It pulses `done` after the last bit has been accepted. It sits between a word-level producer and a bit-serial consumer in the sequential-circuit library.

## Interface
Parameters:
- `WIDTH`, default 8. Data word width; legal range 2..32.

Ports:
- `clk`, input, 1. Sole clock; all state updates on the rising edge.
- `clrn`, input, 1. Reset; synchronous, active-low.
- `in_valid`, input, 1. Producer has a word on `din`.
- `in_ready`, output, 1. Controller can accept a word.
- `din`, input, WIDTH. Parallel word.
- `abort`, input, 1. Synchronous request to cancel the current transfer.
- `sout`, output, 1. Serial data bit.
- `sout_valid`, output, 1. `sout` is valid.
- `sout_ready`, input, 1. Consumer accepts `sout` this cycle.
- `busy`, output, 1. High in LOAD and SHIFT.
- `done`, output, 1. One-cycle pulse after the final bit is accepted.

## Operation
- States:
  - IDLE: waiting for a word.
  - LOAD: chain holds the captured word; present bit 0.
  - SHIFT: serialise the remaining bits.
  - DONE: one-cycle completion state.
- IDLE → LOAD: on `in_valid && in_ready`. `din` is captured into the chain on that edge.
- LOAD → SHIFT: unconditional after one cycle. `sout_valid` rises and `sout` = `din[0]`.
- SHIFT, beat accepted (`sout_valid && sout_ready`): chain shifts right by one and the beat counter increments.
- SHIFT → DONE: on acceptance of beat index BEATS-1. BEATS = WIDTH, or WIDTH+1 with parity enabled.
- DONE → IDLE: unconditional. `done` = 1 for exactly this cycle.
- `in_ready` = (state == IDLE) && !abort. The controller does not accept a word in any other state.
- `busy` = state is LOAD or SHIFT.
- Stall: while `sout_ready` = 0, `sout`, `sout_valid` and the beat counter hold.
- `abort`, in LOAD or SHIFT:
  - next state is IDLE and the chain is cleared to 0;
  - `sout_valid` drops on the next cycle;
  - `done` is not pulsed.
- `abort` in IDLE or DONE has no effect other than masking `in_ready`.
- Final beat accepted in the same cycle as `abort`: abort wins; no DONE and no `done` pulse.
- Reset (`clrn` = 0 at an edge), from any state:
  - state → IDLE, chain → 0, beat counter → 0;
  - `sout` = 0, `sout_valid` = 0, `busy` = 0, `done` = 0;
  - `in_ready` = 1 from the first cycle after reset, provided `abort` = 0.
- A reset in the middle of a transfer discards the word silently.
- Beat counter width: $clog2(WIDTH+2). The counter never wraps, because the exit condition is an exact compare.

## Timing
- A word accepted at edge N gives `sout_valid` = 1 and `sout` = bit 0 from edge N+1.
- With no stalls, bit k appears at N+1+k, `done` is high in cycle N+BEATS+1, and `in_ready` returns at N+BEATS+2.
- Back-to-back word throughput: one word per BEATS+2 cycles.
- `sout`, `sout_valid`, `busy` and `done` are driven directly from flops; there is no combinational path from inputs.
- `in_ready` has one combinational term, from `abort`.

## Configuration
- `DFF_CHAIN_PARITY_EN` defined:
  - one extra beat follows bit WIDTH-1, carrying the even-parity bit (XOR of the captured word);
  - BEATS = WIDTH+1;
  - the parity beat obeys the same stall and abort rules.
- `DFF_CHAIN_PARITY_EN` undefined: BEATS = WIDTH, and no parity logic is present.

## Structure
- Package `dff_chain_pkg` holds:
  - the state enum typedef (IDLE, LOAD, SHIFT, DONE);
  - the default WIDTH constant;
  - a function that computes BEATS from WIDTH and the macro.
- Sub-module `dff_shift_reg` is the WIDTH-bit flip-flop chain. It has synchronous clear, parallel load, shift-right enable and serial output.
- `dff_chain_ctrl` contains the FSM, the beat counter, the parity register and the handshake logic.

## Test plan
- Reset then idle: with `clrn` low for 2 cycles, then high, require `in_ready` = 1 and all other outputs 0.
- Basic transfer, WIDTH=8: `din` = 8'hA5 with `sout_ready` held at 1. Require serial bits 1,0,1,0,0,1,0,1 on consecutive cycles starting at N+1, and `done` at N+9.
- Stall: `din` = 8'h0F. Drop `sout_ready` for 3 cycles on beat 4. Require `sout` = 0 held stable, then bits 4..7 = 0 resume, and `done` delayed by exactly 3 cycles.
- Abort: raise `abort` for 1 cycle during beat 3 of 8'hFF. Require IDLE next cycle, `sout_valid` = 0, no `done`, and the next word 8'h01 serialised correctly.
- Final-beat collision: `abort` asserted in the same cycle the last beat is accepted. Require no `done` pulse.
- Parity (macro defined): `din` = 8'h07. Require 9 beats with beat 8 = 1. Then `din` = 8'h03: beat 8 = 0.

Source files
------------

// File: rtl/dff_chain_pkg.sv
// Shared types and constants for the dff_chain parallel-in/serial-out controller.
// DFF_CHAIN_PARITY_EN adds a trailing even-parity beat after the data bits.
package dff_chain_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Serial beats per word: data bits, plus one parity beat when enabled.
    function automatic int unsigned dff_chain_beats(input int unsigned width);
`ifdef DFF_CHAIN_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/dff_shift_reg.sv
// WIDTH-bit D flip-flop chain: synchronous clear, parallel load, shift right
// with a serial fill bit at the MSB, and the LSB as the serial output.
module dff_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             clr,
    input  logic             load,
    input  logic             shift_en,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] chain_q;
    logic [WIDTH-1:0] chain_d;

    // Clear has priority over load, load over shift.
    always_comb begin
        chain_d = chain_q;
        if (clr) begin
            chain_d = '0;
        end else if (load) begin
            chain_d = din;
        end else if (shift_en) begin
            chain_d = {sin, chain_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sout = chain_q[0];

endmodule

// File: rtl/dff_chain_ctrl.sv
// Sequences a dff_shift_reg as a parallel-in, serial-out shifter (LSB first).
// DFF_CHAIN_PARITY_EN appends an even-parity beat after bit WIDTH-1.
module dff_chain_ctrl
    import dff_chain_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BEATS = dff_chain_beats(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic load_fire;
    logic beat_fire;
    logic chain_clr;
    logic chain_load;
    logic chain_shift;
    logic chain_sin;

    assign in_ready  = (state_q == IDLE) && !abort;
    assign load_fire = in_valid && in_ready;
    assign beat_fire = sout_valid_q && sout_ready;

    // Next state, beat counter and chain control; abort beats a final-beat accept.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sout_valid_d = sout_valid_q;
        chain_clr    = 1'b0;
        chain_load   = 1'b0;
        chain_shift  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    state_d    = LOAD;
                    cnt_d      = '0;
                    chain_load = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    chain_clr = 1'b1;
                end else begin
                    state_d      = SHIFT;
                    sout_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    sout_valid_d = 1'b0;
                    chain_clr    = 1'b1;
                end else if (beat_fire) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d      = DONE;
                        cnt_d        = '0;
                        sout_valid_d = 1'b0;
                        chain_clr    = 1'b1;
                    end else begin
                        cnt_d       = cnt_q + CNT_W'(1);
                        chain_shift = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = '0;
                sout_valid_d = 1'b0;
                chain_clr    = 1'b1;
            end
        endcase
        busy_d = (state_d == LOAD) || (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef DFF_CHAIN_PARITY_EN
    logic parity_q, parity_d;

    // Parity is shifted in at the MSB so it reaches the LSB on beat WIDTH.
    always_comb begin
        parity_d = parity_q;
        if (chain_clr) begin
            parity_d = 1'b0;
        end else if (chain_load) begin
            parity_d = ^din;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign chain_sin = parity_q;
`else
    assign chain_sin = 1'b0;
`endif

    dff_shift_reg #(
        .WIDTH (WIDTH)
    ) u_chain (
        .clk      (clk),
        .clrn     (clrn),
        .clr      (chain_clr),
        .load     (chain_load),
        .shift_en (chain_shift),
        .sin      (chain_sin),
        .din      (din),
        .sout     (sout)
    );

    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dff_chain_ctrl.sv
// Directed testbench for dff_chain_ctrl (WIDTH = 8); honours DFF_CHAIN_PARITY_EN.
module tb_dff_chain_ctrl;

`ifdef DFF_CHAIN_PARITY_EN
    localparam int BEATS = 9;
`else
    localparam int BEATS = 8;
`endif

    logic       clk = 1'b0;
    logic       clrn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       abort;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       busy;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    dff_chain_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .abort      (abort),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected serial bit for beat k of word w.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k < 8) return w[k];
        return ^w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present w for one accepting edge; returns just after that edge (state LOAD).
    task automatic send_word(input logic [7:0] w);
        din      = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0; in_valid = 1'b0; din = 8'h00; abort = 1'b0; sout_ready = 1'b0;
        tick();
        tick();
        clrn = 1'b1;
        tick();
        n_cmp++;
        if ({in_ready, sout, sout_valid, busy, done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_idle: got {rdy,sout,vld,busy,done}=%b want 10000",
                     {in_ready, sout, sout_valid, busy, done});
        end
        abort = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_abort_mask: in_ready=%b want 0", in_ready);
        end
        abort = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        sout_ready = 1'b1;
        send_word(8'hA5);
        n_cmp++;
        if ({sout_valid, busy, in_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL basic_load: got {vld,busy,rdy}=%b want 010", {sout_valid, busy, in_ready});
        end
        for (int k = 0; k < BEATS; k++) begin
            tick();
            n_cmp++;
            if (sout_valid !== 1'b1 || sout !== exp_bit(8'hA5, k) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_beat%0d: vld=%b sout=%b done=%b want vld=1 sout=%b done=0",
                         k, sout_valid, sout, done, exp_bit(8'hA5, k));
            end
        end
        tick();
        n_cmp++;
        if ({done, sout_valid, busy, in_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_done: got {done,vld,busy,rdy}=%b want 1000",
                     {done, sout_valid, busy, in_ready});
        end
        tick();
        n_cmp++;
        if ({done, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_return_idle: got {done,rdy}=%b want 01", {done, in_ready});
        end
    endtask

    task automatic test_stall();
        int cyc;
        sout_ready = 1'b1;
        send_word(8'h0F);
        cyc = 0;
        for (int k = 0; k < BEATS; k++) begin
            tick();
            cyc++;
            n_cmp++;
            if (sout_valid !== 1'b1 || sout !== exp_bit(8'h0F, k)) begin
                n_fail++;
                $display("FAIL stall_beat%0d: vld=%b sout=%b want vld=1 sout=%b",
                         k, sout_valid, sout, exp_bit(8'h0F, k));
            end
            if (k == 4) begin
                sout_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    cyc++;
                    n_cmp++;
                    if ({sout_valid, sout, done} !== 3'b100) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d: got {vld,sout,done}=%b want 100",
                                 s, {sout_valid, sout, done});
                    end
                end
                sout_ready = 1'b1;
            end
        end
        tick();
        cyc++;
        n_cmp++;
        if (done !== 1'b1 || cyc != BEATS + 4) begin
            n_fail++;
            $display("FAIL stall_done: done=%b at cycle %0d want done=1 at cycle %0d",
                     done, cyc, BEATS + 4);
        end
        tick();
    endtask

    task automatic test_abort();
        sout_ready = 1'b1;
        send_word(8'hFF);
        for (int k = 0; k < 4; k++) tick();
        abort = 1'b1;
        #1;
        n_cmp++;
        if ({sout_valid, sout, in_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL abort_beat3: got {vld,sout,rdy}=%b want 110", {sout_valid, sout, in_ready});
        end
        tick();
        abort = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, sout_valid, sout, busy, done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL abort_idle: got {rdy,vld,sout,busy,done}=%b want 10000",
                     {in_ready, sout_valid, sout, busy, done});
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b want 0", done);
        end
        send_word(8'h01);
        for (int k = 0; k < BEATS; k++) begin
            tick();
            n_cmp++;
            if (sout_valid !== 1'b1 || sout !== exp_bit(8'h01, k)) begin
                n_fail++;
                $display("FAIL after_abort_beat%0d: vld=%b sout=%b want vld=1 sout=%b",
                         k, sout_valid, sout, exp_bit(8'h01, k));
            end
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL after_abort_done: done=%b want 1", done);
        end
        tick();
    endtask

    task automatic test_collision();
        sout_ready = 1'b1;
        send_word(8'h81);
        for (int k = 0; k < BEATS; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        n_cmp++;
        if ({done, sout_valid, busy, in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL collision: got {done,vld,busy,rdy}=%b want 0001",
                     {done, sout_valid, busy, in_ready});
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_late_done: done=%b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        sout_ready = 1'b1;
        send_word(8'hC3);
        tick();
        tick();
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, sout, sout_valid, busy, done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_mid: got {rdy,sout,vld,busy,done}=%b want 10000",
                     {in_ready, sout, sout_valid, busy, done});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        sout_ready = 1'b1;
        din        = 8'h3C;
        in_valid   = 1'b1;
        tick();
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != BEATS + 2) begin
            n_fail++;
            $display("FAIL back_to_back_period: in_ready back after %0d cycles want %0d", cyc, BEATS + 2);
        end
        din = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (sout_valid !== 1'b1 || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_second: vld=%b sout=%b want vld=1 sout=0", sout_valid, sout);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_drain: done=%b want 1 within 40 cycles", done);
        end
        tick();
    endtask

`ifdef DFF_CHAIN_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       par   [2];
        words[0] = 8'h07; par[0] = 1'b1;
        words[1] = 8'h03; par[1] = 1'b0;
        sout_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            send_word(words[w]);
            for (int k = 0; k < 9; k++) tick();
            n_cmp++;
            if (sout_valid !== 1'b1 || sout !== par[w] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_beat8_w%0d: vld=%b sout=%b done=%b want vld=1 sout=%b done=0",
                         w, sout_valid, sout, done, par[w]);
            end
            tick();
            n_cmp++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL parity_done_w%0d: done=%b want 1", w, done);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_collision();
        test_reset_mid();
        test_back_to_back();
`ifdef DFF_CHAIN_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
